// File: rtl/threshold_classifier.sv
// threshold_classifier: sliced multi-threshold compare with hysteresis-filtered seven-segment class display
module threshold_classifier #(
    parameter int WIDTH = 8,
    parameter int NIB = 4,
    parameter int NTHR = 3,
    parameter int HOLD = 2,
    parameter logic [NTHR*WIDTH-1:0] THR_INIT = {8'hC2, 8'h74, 8'h27}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_idx,
    input  logic [WIDTH-1:0] cfg_data,
    output logic             cfg_ready,
    output logic             res_valid,
    output logic [NTHR-1:0]  res_lt,
    output logic [NTHR-1:0]  res_eq,
    output logic [NTHR-1:0]  res_gt,
    output logic [3:0]       res_class,
    output logic [3:0]       disp_class,
    output logic [6:0]       seg
);
    localparam int NS = WIDTH / NIB;
    localparam int PW = (NS > 1) ? $clog2(NS) : 1;
    localparam int CW = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [PW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_sample;
    logic [WIDTH-1:0] r_thr [NTHR];
    logic [NTHR-1:0]  r_lt, r_gt;
    logic             r_valid;
    logic [NTHR-1:0]  r_res_lt, r_res_eq, r_res_gt;
    logic [3:0]       r_class, r_disp, r_pend;
    logic [CW-1:0]    r_cnt;
    logic [NTHR-1:0]  w_lt_nx, w_gt_nx;
    logic [3:0]       w_class;
    logic [CW-1:0]    w_cnt_nx;
    logic             w_idle, w_last;

    assign w_idle     = r_state == S_IDLE;
    assign w_last     = r_ptr == '0;
    assign in_ready   = w_idle;
    assign cfg_ready  = w_idle;
    assign res_valid  = r_valid;
    assign res_lt     = r_res_lt;
    assign res_eq     = r_res_eq;
    assign res_gt     = r_res_gt;
    assign res_class  = r_class;
    assign disp_class = r_disp;

    // Thresholds still undecided (neither lt nor gt) resolve on the current slice; decided ones stick
    genvar k;
    generate
        for (k = 0; k < NTHR; k++) begin : g_cmp
            logic [NIB-1:0] w_s, w_t;
            assign w_s = r_sample[r_ptr*NIB +: NIB];
            assign w_t = r_thr[k][r_ptr*NIB +: NIB];
            assign w_lt_nx[k] = r_lt[k] | (!r_gt[k] && w_s < w_t);
            assign w_gt_nx[k] = r_gt[k] | (!r_lt[k] && w_s > w_t);
        end
    endgenerate

    // Class is the number of thresholds strictly below the sample
    always_comb begin
        w_class = '0;
        for (int i = 0; i < NTHR; i++) w_class = w_class + 4'(w_gt_nx[i]);
    end

    assign w_cnt_nx = (w_class == r_pend) ? r_cnt + 1'b1 : CW'(1);

    // Threshold registers are writable only while idle; out-of-range indices match nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTHR; i++) r_thr[i] <= THR_INIT[i*WIDTH +: WIDTH];
        end else begin
            for (int i = 0; i < NTHR; i++)
                if (cfg_we && w_idle && cfg_idx == 4'(i)) r_thr[i] <= cfg_data;
        end
    end

    // Control FSM plus per-slice compare state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_sample <= '0;
            r_lt     <= '0;
            r_gt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_state  <= S_CMP;
                    r_sample <= in_data;
                    r_ptr    <= PW'(NS - 1);
                    r_lt     <= '0;
                    r_gt     <= '0;
                end
                S_CMP: begin
                    r_lt    <= w_lt_nx;
                    r_gt    <= w_gt_nx;
                    r_ptr   <= r_ptr - 1'b1;
                    r_state <= w_last ? S_DONE : S_CMP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Results are captured on the last slice and held until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_res_lt <= '0;
            r_res_eq <= '0;
            r_res_gt <= '0;
            r_class  <= '0;
        end else begin
            r_valid <= r_state == S_CMP && w_last;
            if (r_state == S_CMP && w_last) begin
                r_res_lt <= w_lt_nx;
                r_res_gt <= w_gt_nx;
                r_res_eq <= ~(w_lt_nx | w_gt_nx);
                r_class  <= w_class;
            end
        end
    end

    // Displayed class changes only after HOLD consecutive agreeing different results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= '0;
            r_pend <= '0;
            r_cnt  <= '0;
        end else if (r_state == S_CMP && w_last) begin
            if (w_class == r_disp) begin
                r_cnt <= '0;
            end else begin
                r_pend <= w_class;
                r_cnt  <= (w_cnt_nx == CW'(HOLD)) ? '0 : w_cnt_nx;
                if (w_cnt_nx == CW'(HOLD)) r_disp <= w_class;
            end
        end
    end

    // Active-low {a,b,c,d,e,f,g} digit decode; out-of-range values blank the digit
    always_comb begin
        case (r_disp)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    end
endmodule
